// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-write controller: frame layout,
// peripheral register map and FSM state encoding.
package spi_pkg;

  localparam int FRAME_W  = 16;
  localparam int RW_BIT   = 15;
  localparam int ADDR_MSB = 14;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;

  localparam logic [6:0] REG_EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] REG_EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] REG_EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] REG_EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] REG_PWM_DUTY    = 7'h04;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_e;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/spi_ctrl_tick.sv
// Loadable phase down-counter shared by every timed controller state;
// tc flags the last cycle of a loaded interval (count == 1).
module spi_ctrl_tick #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)               cnt_d = load_val;
    else if (cnt_q != '0)   cnt_d = cnt_q - ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == ONE);

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 register-write controller: serializes {rw, addr[6:0], data[7:0]} MSB first.
// Optional read-back (CIPO, rd_data, rd_valid) is enabled by defining SPI_CTRL_CIPO_EN.
//
// state | meaning
// IDLE  | ready for a request; the done cycle is the first IDLE cycle
// SETUP | nCS low, SCLK low, COPI = frame[15]
// SHIFT | 16 bits, each a low then a high SCLK phase of CLK_DIV cycles
// HOLD  | nCS low after the last falling SCLK edge
// GAP   | nCS high; the final gap cycle is spent in IDLE with done set
module spi_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_GAP   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic       done,
  output logic       nCS,
  output logic       SCLK,
  output logic       COPI
`ifdef SPI_CTRL_CIPO_EN
  ,
  input  logic       CIPO,
  output logic [7:0] rd_data,
  output logic       rd_valid
`endif
);

  localparam int PW = $clog2(max4(CLK_DIV, CS_SETUP, CS_HOLD, CS_GAP) + 1);
  localparam logic [PW-1:0] SETUP_LD = PW'(CS_SETUP);
  localparam logic [PW-1:0] DIV_LD   = PW'(CLK_DIV);
  localparam logic [PW-1:0] HOLD_LD  = PW'(CS_HOLD);
  localparam logic [PW-1:0] GAP_LD   = PW'(CS_GAP - 1);

  state_e              state_q, state_d;
  logic [FRAME_W-1:0]  frame_q, frame_d;
  logic [4:0]          bit_q, bit_d;
  logic                high_q, high_d;
  logic                ncs_q, ncs_d;
  logic                sclk_q, sclk_d;
  logic                copi_q, copi_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ready_q, ready_d;
  logic                ld;
  logic [PW-1:0]       ld_val;
  logic                tc;
  logic                rw_in;
  logic [3:0]          bit_nxt;

`ifdef SPI_CTRL_CIPO_EN
  logic [7:0] rd_shift_q, rd_shift_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       rd_valid_q, rd_valid_d;
  assign rw_in = req_rw;
`else
  logic unused_rw;
  assign unused_rw = req_rw;
  assign rw_in     = 1'b1;
`endif

  assign bit_nxt = bit_q[3:0] - 4'd1;

  spi_ctrl_tick #(.W(PW)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .load     (ld),
    .load_val (ld_val),
    .tc       (tc)
  );

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    bit_d   = bit_q;
    high_d  = high_q;
    ncs_d   = ncs_q;
    sclk_d  = sclk_q;
    copi_d  = copi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ready_d = ready_q;
    ld      = 1'b0;
    ld_val  = '0;
`ifdef SPI_CTRL_CIPO_EN
    rd_shift_d = rd_shift_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (req_valid && ready_q) begin
          state_d = ST_SETUP;
          frame_d = {rw_in, req_addr, req_data};
          bit_d   = 5'd15;
          high_d  = 1'b0;
          ncs_d   = 1'b0;
          copi_d  = rw_in;
          busy_d  = 1'b1;
          ready_d = 1'b0;
          ld      = 1'b1;
          ld_val  = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (tc) begin
          state_d = ST_SHIFT;
          copi_d  = frame_q[RW_BIT];
          ld      = 1'b1;
          ld_val  = DIV_LD;
        end
      end
      ST_SHIFT: begin
        if (tc) begin
          ld     = 1'b1;
          ld_val = DIV_LD;
          if (!high_q) begin
            high_d = 1'b1;
            sclk_d = 1'b1;
          end else begin
`ifdef SPI_CTRL_CIPO_EN
            // Last cycle of a data-bit high phase: peripheral output is settled.
            if (!frame_q[RW_BIT] && bit_q < 5'd8)
              rd_shift_d = {rd_shift_q[6:0], CIPO};
`endif
            high_d = 1'b0;
            sclk_d = 1'b0;
            if (bit_q == 5'd0) begin
              state_d = ST_HOLD;
              ld_val  = HOLD_LD;
            end else begin
              bit_d  = bit_q - 5'd1;
              copi_d = frame_q[bit_nxt];
            end
          end
        end
      end
      ST_HOLD: begin
        if (tc) begin
          state_d = ST_GAP;
          ncs_d   = 1'b1;
          copi_d  = 1'b0;
          ld      = 1'b1;
          ld_val  = GAP_LD;
        end
      end
      ST_GAP: begin
        if (tc) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          ready_d = 1'b1;
          busy_d  = 1'b0;
`ifdef SPI_CTRL_CIPO_EN
          if (!frame_q[RW_BIT]) begin
            rd_data_d  = rd_shift_q;
            rd_valid_d = 1'b1;
          end
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      frame_q <= '0;
      bit_q   <= '0;
      high_q  <= 1'b0;
      ncs_q   <= 1'b1;
      sclk_q  <= 1'b0;
      copi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      bit_q   <= bit_d;
      high_q  <= high_d;
      ncs_q   <= ncs_d;
      sclk_q  <= sclk_d;
      copi_q  <= copi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

`ifdef SPI_CTRL_CIPO_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_shift_q <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_shift_q <= rd_shift_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign nCS       = ncs_q;
  assign SCLK      = sclk_q;
  assign COPI      = copi_q;

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: default-parameter instance with a peripheral
// model, plus a minimum-timing instance. Read-back checks need SPI_CTRL_CIPO_EN.
module tb_spi_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst, req_valid, req_ready, req_rw, busy, done, nCS, SCLK, COPI;
  logic [6:0] req_addr;
  logic [7:0] req_data;
  logic       f_rst, f_valid, f_ready, f_rw, f_busy, f_done, f_ncs, f_sclk, f_copi;
  logic [6:0] f_addr;
  logic [7:0] f_data;
`ifdef SPI_CTRL_CIPO_EN
  logic       cipo, rd_valid, f_cipo, f_rd_valid;
  logic [7:0] rd_data, f_rd_data, m_rdval;
`endif

  spi_controller u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_data(req_data), .busy(busy), .done(done),
    .nCS(nCS), .SCLK(SCLK), .COPI(COPI)
`ifdef SPI_CTRL_CIPO_EN
    , .CIPO(cipo), .rd_data(rd_data), .rd_valid(rd_valid)
`endif
  );

  spi_controller #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(4)) u_fast (
    .clk(clk), .rst(f_rst), .req_valid(f_valid), .req_ready(f_ready), .req_rw(f_rw),
    .req_addr(f_addr), .req_data(f_data), .busy(f_busy), .done(f_done),
    .nCS(f_ncs), .SCLK(f_sclk), .COPI(f_copi)
`ifdef SPI_CTRL_CIPO_EN
    , .CIPO(f_cipo), .rd_data(f_rd_data), .rd_valid(f_rd_valid)
`endif
  );

  // Peripheral model and timing monitors, all sampled on the falling edge.
  logic [15:0] m_sh = '0, m_last = '0;
  logic [7:0]  m_regs [0:4];
  int m_cnt = 0, m_frames = 0;
  logic ncs_prev = 1'b1, sclk_prev = 1'b0, f_sclk_prev = 1'b0;
  int low_run = 0, last_low = 0, high_run = 0, last_high = 0, done_cnt = 0, rdy_busy = 0;
  int f_low_run = 0, f_last_low = 0, f_last_rise = -1, f_period = 0;

`ifdef SPI_CTRL_CIPO_EN
  always_comb begin
    cipo = 1'b0;
    if (m_cnt >= 9 && m_cnt <= 16) cipo = m_rdval[3'(16 - m_cnt)];
  end
  assign f_cipo = 1'b0;
`endif

  always @(negedge clk) begin
    if (!nCS && ncs_prev) m_cnt = 0;
    if (!nCS && SCLK && !sclk_prev) begin
      m_sh  = {m_sh[14:0], COPI};
      m_cnt = m_cnt + 1;
    end
    if (nCS && !ncs_prev && m_cnt == 16) begin
      m_last   = m_sh;
      m_frames = m_frames + 1;
      if (m_sh[15] && m_sh[14:11] == 4'd0 && m_sh[10:8] <= 3'd4) m_regs[m_sh[10:8]] = m_sh[7:0];
    end
    if (!nCS) begin
      low_run = low_run + 1;
      if (high_run > 0) last_high = high_run;
      high_run = 0;
    end else begin
      high_run = high_run + 1;
      if (low_run > 0) last_low = low_run;
      low_run = 0;
    end
    if (done) done_cnt = done_cnt + 1;
    if (busy && req_ready) rdy_busy = rdy_busy + 1;
    ncs_prev  = nCS;
    sclk_prev = SCLK;
    if (!f_ncs) f_low_run = f_low_run + 1;
    else begin
      if (f_low_run > 0) f_last_low = f_low_run;
      f_low_run = 0;
    end
    if (f_sclk && !f_sclk_prev) begin
      if (f_last_rise >= 0) f_period = cyc - f_last_rise;
      f_last_rise = cyc;
    end
    f_sclk_prev = f_sclk;
  end

  int n_checks = 0, n_errors = 0;
  int t_acc = 0, t_done = 0, frames0 = 0, done0 = 0;
  logic ok;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Presents a request and returns one cycle after the accept edge (t_acc).
  task automatic issue(input logic rw, input logic [6:0] a, input logic [7:0] d);
    req_rw = rw; req_addr = a; req_data = d; req_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (req_ready) begin
        t_acc = cyc + 1;
        step();
        return;
      end
      step();
    end
    check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        t_done = cyc;
        return;
      end
      step();
    end
    check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
`ifdef SPI_CTRL_CIPO_EN
    m_rdval = 8'h3C;
`endif
    rst = 1'b1; req_valid = 1'b0; req_rw = 1'b1; req_addr = '0; req_data = '0;
    f_rst = 1'b1; f_valid = 1'b0; f_rw = 1'b1; f_addr = '0; f_data = '0;
    repeat (3) step();
    check("rst_ncs", nCS, 1);
    check("rst_sclk", SCLK, 0);
    check("rst_copi", COPI, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", req_ready, 0);
    rst = 1'b0; f_rst = 1'b0;
    step();
    check("ready_after_rst", req_ready, 1);

    // Single write, with req_data churning while busy.
    issue(1'b1, 7'h00, 8'hA5);
    req_valid = 1'b0;
    check("a_busy", busy, 1);
    check("a_ncs_low", nCS, 0);
    check("a_ready_low", req_ready, 0);
    for (int i = 0; i < 60; i++) begin
      req_valid = 1'b1;
      req_data  = (i % 2 == 0) ? 8'h3C : 8'hC3;
      step();
    end
    req_valid = 1'b0;
    wait_done(300);
    check("a_latency", t_done - t_acc + 1, 144);
    check("a_ready_in_done", req_ready, 1);
    repeat (4) step();
    check("a_ncs_low_cycles", last_low, 136);
    check("a_frame", m_last, 16'h80A5);
    check("a_reg_en_out_7_0", m_regs[0], 8'hA5);
    check("a_frames", m_frames, 1);
    check("a_ready_while_busy", rdy_busy, 0);
    check("a_no_extra_accept", busy, 0);

    // Back-to-back writes: the second is accepted in the first's done cycle.
    issue(1'b1, 7'h04, 8'h80);
    req_addr = 7'h02; req_data = 8'hFF;
    wait_done(300);
    check("b1_latency", t_done - t_acc + 1, 144);
    check("b_ready_in_done", req_ready, 1);
    t_acc = cyc + 1;
    step();
    req_valid = 1'b0;
    check("b_second_busy", busy, 1);
    check("b_gap_cycles", last_high, 8);
    wait_done(300);
    check("b2_latency", t_done - t_acc + 1, 144);
    repeat (4) step();
    check("b_reg_duty", m_regs[4], 8'h80);
    check("b_reg_en_pwm_7_0", m_regs[2], 8'hFF);
    check("b_frames", m_frames, 3);

    // Reset during the high phase of bit 8.
    frames0 = m_frames;
    done0   = done_cnt;
    issue(1'b1, 7'h01, 8'h5A);
    req_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (SCLK && m_cnt == 8) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check("r_reached_bit8", ok, 1);
    rst = 1'b1;
    step();
    check("r_ncs", nCS, 1);
    check("r_sclk", SCLK, 0);
    check("r_copi", COPI, 0);
    check("r_busy", busy, 0);
    check("r_ready", req_ready, 0);
    rst = 1'b0;
    step();
    check("r_ready_after", req_ready, 1);
    repeat (20) step();
    check("r_no_done", done_cnt, done0);
    check("r_frame_dropped", m_frames, frames0);
    check("r_reg_untouched", m_regs[1], 8'h00);

`ifdef SPI_CTRL_CIPO_EN
    issue(1'b0, 7'h04, 8'h00);
    req_valid = 1'b0;
    wait_done(300);
    check("rd_valid_with_done", rd_valid, 1);
    check("rd_data", rd_data, 8'h3C);
    repeat (2) step();
    check("rd_frame_bit15", m_last, 16'h0400);
    check("rd_valid_pulse", rd_valid, 0);
    check("rd_reg_unchanged", m_regs[4], 8'h80);
`endif

    // Minimum-timing instance.
    f_rw = 1'b1; f_addr = 7'h03; f_data = 8'h12; f_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (f_ready) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check("f_ready", ok, 1);
    t_acc = cyc + 1;
    step();
    f_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (f_done) begin
        ok = 1'b1;
        t_done = cyc;
        break;
      end
      step();
    end
    check("f_done_seen", ok, 1);
    check("f_latency", t_done - t_acc + 1, 38);
    check("f_sclk_period", f_period, 2);
    check("f_ncs_low_cycles", f_last_low, 34);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_controller.md
# spi_controller

SPI mode-0 controller that drives the three-wire write interface (nCS, SCLK, COPI) of the chip's SPI register peripheral. It accepts register write requests over a valid/ready handshake and serializes each one as a 16-bit frame: R/W bit, 7-bit address, 8-bit data, MSB first. It is used by on-chip test and bring-up logic to program the output-enable, PWM-enable and duty-cycle registers without an external host.

## Interface
Parameters:
- CLK_DIV, 4: clk cycles per SCLK half-period; must be ≥1.
- CS_SETUP, 4: clk cycles with nCS low before the first SCLK rising edge; must be ≥1.
- CS_HOLD, 4: clk cycles with nCS low after the last SCLK falling edge; must be ≥1.
- CS_GAP, 8: clk cycles with nCS high after each frame; must be ≥4, which covers the peripheral's 3-stage synchronizer.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present; held stable until accepted.
- req_ready  out  1  high only in IDLE.
- req_rw  in  1  1 = write; ignored (forced 1) without SPI_CTRL_CIPO_EN.
- req_addr  in  7  register address; passed through unchecked (peripheral decodes 0x00–0x04).
- req_data  in  8  write data.
- busy  out  1  high from the cycle after accept until return to IDLE.
- done  out  1  one-cycle pulse at frame completion.
- nCS  out  1  chip select, active low.
- SCLK  out  1  serial clock, idle low.
- COPI  out  1  serial data out.

## Operation
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
- Accept occurs when req_valid && req_ready. The frame is latched as {req_rw, req_addr, req_data}.
- SETUP: nCS=0, SCLK=0, COPI=frame[15]. Lasts CS_SETUP cycles.
- SHIFT covers bits 15 down to 0. For each bit:
  - Low phase: SCLK=0 for CLK_DIV cycles, COPI=current bit.
  - High phase: SCLK=1 for CLK_DIV cycles.
  - COPI changes only in the first cycle of a low phase, so it is stable across each rising edge.
- HOLD: SCLK=0, nCS=0, COPI holds bit 0. Lasts CS_HOLD cycles.
- GAP: nCS=1, SCLK=0, COPI=0. Lasts CS_GAP cycles.
- GAP→IDLE transition: done=1 for that one cycle, and req_ready=1 in the same cycle.
- A 5-bit bit counter counts 15→0. The phase counter is $clog2(max(CLK_DIV, CS_SETUP, CS_HOLD, CS_GAP)+1) bits wide and counts down to 1.

## Timing
- Reset values: nCS=1, SCLK=0, COPI=0, busy=0, done=0, req_ready=0 while rst is high. req_ready=1 on the first cycle after rst falls.
- Latency from accept edge to done: CS_SETUP + 32·CLK_DIV + CS_HOLD + CS_GAP cycles. With defaults this is 144.
- Back-to-back requests: a request may be accepted in the done cycle. That request's SETUP begins on the next cycle, so nCS is high for exactly CS_GAP cycles between frames.
- Requests while busy are ignored: no sampling, and req_ready stays 0.
- Reset mid-frame: on the next edge all outputs take their reset values and the state returns to IDLE. No done pulse; the frame is dropped.

## Configuration
- SPI_CTRL_CIPO_EN defined adds three ports:
  - CIPO in 1.
  - rd_data out 8, reset 0.
  - rd_valid out 1, reset 0.
- With SPI_CTRL_CIPO_EN, req_rw is honoured. For a read (req_rw=0), CIPO is sampled on the last clk cycle of each high phase for bits 7..0 and shifted in MSB first. rd_data updates and rd_valid pulses in the done cycle; write frames leave rd_data unchanged.
- Without SPI_CTRL_CIPO_EN: no CIPO logic, frame bit 15 is always 1.

## Structure
- Package spi_pkg contains:
  - FRAME_W=16 and field positions: RW_BIT=15, ADDR_MSB=14, ADDR_LSB=8, DATA_MSB=7.
  - Register address constants: REG_EN_OUT_7_0=0x00, REG_EN_OUT_15_8=0x01, REG_EN_PWM_7_0=0x02, REG_EN_PWM_15_8=0x03, REG_PWM_DUTY=0x04.
  - The state enum.
- Sub-module spi_ctrl_tick: the loadable phase down-counter with a terminal-count output, shared by all timed states.

## Test plan
- Defaults, write addr 0x00 data 0xA5 → COPI on the 16 rising SCLK edges is 1,0000000,10100101. nCS is low for 4+128+4 cycles. done arrives 144 cycles after accept. A peripheral model's en_reg_out_7_0 reads 0xA5.
- Two writes held back-to-back (0x04/0x80, then 0x02/0xFF) → second is accepted in the first's done cycle. nCS is high exactly 8 cycles between frames. Both registers update.
- rst pulsed during the high phase of bit 8 → next cycle nCS=1, SCLK=0, COPI=0, busy=0, no done. req_ready=1 one cycle after rst falls.
- req_data toggled while busy → no effect on the in-flight frame and no extra accept.
- CLK_DIV=1, CS_SETUP=1, CS_HOLD=1, CS_GAP=4 → SCLK period is 2 cycles and done arrives 38 cycles after accept.
- SPI_CTRL_CIPO_EN, read addr 0x04 with the model driving 0x3C on CIPO → frame bit 15 is 0, rd_data=0x3C, and rd_valid coincides with done.
